// File: rtl/ac97_frame_gen.sv
// AC97 output frame serialiser: slot 0 tag, slot 1/2 register write, slot 3/4 PCM.
// Optional build macro AC97_HOLD_ON_UNDERRUN_EN repeats the last accepted sample on underrun.
module ac97_frame_gen #(
  parameter int          SAMPLE_WIDTH = 20,
  parameter logic [1:0]  CODEC_ID     = 2'b00
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [6:0]              cmd_addr,
  input  logic [15:0]             cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic                    underrun,
  output logic                    sdata_out,
  output logic                    sync
);

  localparam int PAD = 20 - SAMPLE_WIDTH;

  logic [7:0]              bit_cnt_q, bit_cnt_d;
  logic                    pcm_v_q, pcm_v_d;
  logic                    cmd_v_q, cmd_v_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic [6:0]              addr_q, addr_d;
  logic [15:0]             data_q, data_d;
  logic                    underrun_q, underrun_d;
  logic                    sdata_q, sdata_d;
  logic                    sync_q, sync_d;

  logic                    frame_end;
  logic                    sample_xfer;
  logic                    cmd_xfer;
  logic [15:0]             tag;
  logic [19:0]             slot1;
  logic [19:0]             slot2;
  logic [19:0]             pcm_slot;
  logic [95:0]             frame_head;
  logic [95:0]             frame_serial;

  assign frame_end    = (bit_cnt_q == 8'hFF);
  assign sample_ready = frame_end && rst_b;
  assign cmd_ready    = frame_end && rst_b;
  assign sample_xfer  = sample_valid && sample_ready;
  assign cmd_xfer     = cmd_valid && cmd_ready;

  // Slots are built only from the latches, never from the live inputs.
  assign tag      = {cmd_v_q | pcm_v_q, cmd_v_q, cmd_v_q, pcm_v_q, pcm_v_q, 9'b0, CODEC_ID};
  assign slot1    = {1'b0, addr_q, 12'b0};
  assign slot2    = {data_q, 4'b0};
  assign pcm_slot = pcm_v_q ? (20'(sample_q) << PAD) : 20'b0;

  assign frame_head = {tag, slot1, slot2, pcm_slot, pcm_slot};

  // Bit-reverse the head so the bit counter indexes it directly, MSB first on the wire.
  genvar gi;
  generate
    for (gi = 0; gi < 96; gi++) begin : g_serial
      assign frame_serial[gi] = frame_head[95-gi];
    end
  endgenerate

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 8'd1;
    pcm_v_d    = pcm_v_q;
    cmd_v_d    = cmd_v_q;
    sample_d   = sample_q;
    addr_d     = addr_q;
    data_d     = data_q;
    underrun_d = frame_end && !sample_valid;
    sdata_d    = (bit_cnt_q < 8'd96) ? frame_serial[bit_cnt_q[6:0]] : 1'b0;
    sync_d     = (bit_cnt_q < 8'd16);

    if (frame_end) begin
      cmd_v_d = cmd_xfer;
      addr_d  = cmd_xfer ? cmd_addr : 7'd0;
      data_d  = cmd_xfer ? cmd_data : 16'd0;
`ifdef AC97_HOLD_ON_UNDERRUN_EN
      pcm_v_d  = sample_xfer | pcm_v_q;
      sample_d = sample_xfer ? sample : sample_q;
`else
      pcm_v_d  = sample_xfer;
      sample_d = sample_xfer ? sample : '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_cnt_q  <= 8'd0;
      pcm_v_q    <= 1'b0;
      cmd_v_q    <= 1'b0;
      sample_q   <= '0;
      addr_q     <= 7'd0;
      data_q     <= 16'd0;
      underrun_q <= 1'b0;
      sdata_q    <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      pcm_v_q    <= pcm_v_d;
      cmd_v_q    <= cmd_v_d;
      sample_q   <= sample_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      sdata_q    <= sdata_d;
      sync_q     <= sync_d;
    end
  end

  assign underrun  = underrun_q;
  assign sdata_out = sdata_q;
  assign sync      = sync_q;

endmodule

// File: tb/tb_ac97_frame_gen.sv
// Self-checking bench for ac97_frame_gen: whole-frame captures compared against a slot-level model.
module tb_ac97_frame_gen;
  localparam int         SW  = 20;
  localparam logic [1:0] CID = 2'b01;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [6:0]    cmd_addr = '0;
  logic [15:0]   cmd_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          underrun;
  logic          sdata_out;
  logic          sync;

  int total = 0;
  int bad   = 0;

  // Model of what the block has accepted for the frame now being sent.
  logic          m_pv, m_cv;
  logic [SW-1:0] m_smp;
  logic [6:0]    m_addr;
  logic [15:0]   m_data;
  logic [255:0]  last_sd;

  ac97_frame_gen #(.SAMPLE_WIDTH(SW), .CODEC_ID(CID)) dut (
    .clk(clk), .rst_b(rst_b),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .underrun(underrun), .sdata_out(sdata_out), .sync(sync)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pv = 0; m_cv = 0; m_smp = '0; m_addr = '0; m_data = '0;
  endfunction

  // Expected frame; index n is the n-th bit on the wire.
  function automatic logic [255:0] model_frame();
    logic [255:0] f;
    logic [15:0]  tag;
    int unsigned  v1, v2, v34;
    logic [19:0]  s1, s2, s34;
    f = '0;
    tag = 16'(CID);
    if (m_cv || m_pv) tag = tag + 16'h8000;
    if (m_cv) tag = tag + 16'h6000;
    if (m_pv) tag = tag + 16'h1800;
    v1  = m_cv ? m_addr * 4096 : 0;
    v2  = m_cv ? m_data * 16 : 0;
    v34 = m_pv ? m_smp * (1 << (20 - SW)) : 0;
    s1 = v1[19:0]; s2 = v2[19:0]; s34 = v34[19:0];
    for (int n = 0; n < 256; n++) begin
      if (n < 16)      f[n] = tag[15-n];
      else if (n < 36) f[n] = s1[19-(n-16)];
      else if (n < 56) f[n] = s2[19-(n-36)];
      else if (n < 76) f[n] = s34[19-(n-56)];
      else if (n < 96) f[n] = s34[19-(n-76)];
    end
    return f;
  endfunction

  function automatic int unsigned field(input logic [255:0] v, input int start, input int len);
    int unsigned r = 0;
    for (int i = 0; i < len; i++) r = (r << 1) | int'(v[start+i]);
    return r;
  endfunction

  // One full frame; offers are held (after optional mid-frame junk) and take effect next frame.
  task automatic run_frame(input logic sv, input logic [SW-1:0] s, input logic cv,
                           input logic [6:0] a, input logic [15:0] d,
                           input bit scramble, input string name);
    logic [255:0] exp_sd, exp_sy, exp_rdy, exp_ur;
    logic [255:0] got_sd, got_sy, got_srdy, got_crdy, got_ur;
    sample_valid = sv; cmd_valid = cv;
    if (scramble) begin
      sample = SW'($urandom); cmd_addr = 7'($urandom); cmd_data = 16'($urandom);
    end else begin
      sample = s; cmd_addr = a; cmd_data = d;
    end
    exp_sd  = model_frame();
    exp_sy  = 256'hFFFF;
    exp_rdy = 256'd1 << 254;
    exp_ur  = sv ? 256'd0 : (256'd1 << 255);
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      got_sd[k] = sdata_out; got_sy[k] = sync; got_ur[k] = underrun;
      got_srdy[k] = sample_ready; got_crdy[k] = cmd_ready;
      if (k == 128) begin
        sample = s; cmd_addr = a; cmd_data = d;
      end
    end
    last_sd = got_sd;
    total += 5;
    if (got_sd !== exp_sd) begin
      bad++; $display("FAIL %s sdata got=%h exp=%h", name, got_sd, exp_sd);
    end
    if (got_sy !== exp_sy) begin
      bad++; $display("FAIL %s sync got=%h exp=%h", name, got_sy, exp_sy);
    end
    if (got_srdy !== exp_rdy) begin
      bad++; $display("FAIL %s sample_ready got=%h exp=%h", name, got_srdy, exp_rdy);
    end
    if (got_crdy !== exp_rdy) begin
      bad++; $display("FAIL %s cmd_ready got=%h exp=%h", name, got_crdy, exp_rdy);
    end
    if (got_ur !== exp_ur) begin
      bad++; $display("FAIL %s underrun got=%h exp=%h", name, got_ur, exp_ur);
    end
    $display("frame %s: tag=%04h sv=%0b cv=%0b", name, field(got_sd, 0, 16), sv, cv);
    m_cv   = cv;
    m_addr = cv ? a : 7'd0;
    m_data = cv ? d : 16'd0;
`ifdef AC97_HOLD_ON_UNDERRUN_EN
    m_pv  = sv | m_pv;
    m_smp = sv ? s : m_smp;
`else
    m_pv  = sv;
    m_smp = sv ? s : '0;
`endif
  endtask

  task automatic check_field(input string name, input int start, input int len, input int unsigned exp);
    int unsigned got;
    got = field(last_sd, start, len);
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sdata_out, sync, underrun, sample_ready, cmd_ready} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000",
                      {sdata_out, sync, underrun, sample_ready, cmd_ready});
    end
    $display("reset: outputs=%b", {sdata_out, sync, underrun, sample_ready, cmd_ready});
    release_reset();
  endtask

  task automatic test_idle();
    run_frame(0, '0, 0, '0, '0, 0, "idle0");
    check_field("idle0_tag", 0, 16, 32'h0001);
    run_frame(0, '0, 0, '0, '0, 0, "idle1");
  endtask

  task automatic test_cmd();
    run_frame(0, '0, 1, 7'h02, 16'h0808, 0, "cmd_offer");
    run_frame(0, '0, 0, '0, '0, 0, "cmd_show");
    check_field("cmd_tag", 0, 16, 32'hE001);
    check_field("cmd_slot1", 16, 20, 32'h02000);
    check_field("cmd_slot2", 36, 20, 32'h08080);
    run_frame(0, '0, 0, '0, '0, 0, "cmd_after");
    check_field("cmd_after_tag", 0, 16, 32'h0001);
  endtask

  task automatic test_sample();
    run_frame(1, 20'hA5A5A, 0, '0, '0, 0, "smp_offer");
    run_frame(1, 20'hA5A5A, 0, '0, '0, 0, "smp_show");
    check_field("smp_tag", 0, 16, 32'h9801);
    check_field("smp_slot3", 56, 20, 32'hA5A5A);
    check_field("smp_slot4", 76, 20, 32'hA5A5A);
  endtask

  task automatic test_both();
    run_frame(1, 20'h12345, 1, 7'h55, 16'hBEEF, 0, "both_offer");
    run_frame(1, 20'h12345, 0, '0, '0, 0, "both_show");
    check_field("both_tag", 0, 16, 32'hF801);
    check_field("both_slot1", 16, 20, 32'h55000);
    check_field("both_slot2", 36, 20, 32'hBEEF0);
  endtask

  task automatic test_underrun();
    run_frame(1, 20'h0F0F3, 0, '0, '0, 0, "ur_offer");
    run_frame(0, '0, 0, '0, '0, 0, "ur_withdrawn");
    check_field("ur_show_slot3", 56, 20, 32'h0F0F3);
    run_frame(0, '0, 0, '0, '0, 0, "ur_next");
`ifdef AC97_HOLD_ON_UNDERRUN_EN
    check_field("ur_tag", 0, 16, 32'h9801);
    check_field("ur_slot4", 76, 20, 32'h0F0F3);
`else
    check_field("ur_tag", 0, 16, 32'h0001);
    check_field("ur_slot4", 76, 20, 32'h00000);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_frame(1'($urandom), SW'($urandom), 1'($urandom), 7'($urandom), 16'($urandom),
                1, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    logic pre_bit;
    run_frame(0, '0, 1, 7'h02, 16'h0808, 0, "mid_offer");
    sample_valid = 0; cmd_valid = 0;
    // Data bit 11 of 0x0808 is wire bit 40 of the command frame.
    repeat (41) @(posedge clk);
    #1;
    pre_bit = sdata_out;
    total++;
    if (pre_bit !== 1'b1) begin
      bad++; $display("FAIL mid_bit40 got=%b exp=1", pre_bit);
    end
    rst_b = 1'b0;
    #1;
    total++;
    if ({sdata_out, sync, underrun, sample_ready} !== 4'b0) begin
      bad++; $display("FAIL mid_async_clear got=%b exp=0000", {sdata_out, sync, underrun, sample_ready});
    end
    $display("mid reset: bit40=%b after=%b", pre_bit, {sdata_out, sync, underrun, sample_ready});
    repeat (2) @(posedge clk);
    release_reset();
    run_frame(0, '0, 0, '0, '0, 0, "mid_after");
    check_field("mid_after_tag", 0, 16, 32'h0001);
    check_field("mid_after_slot1", 16, 20, 32'h0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_cmd();
    test_sample();
    test_both();
    test_underrun();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
